// File: rtl/router_pkg.sv
// Shared definitions for the buffer read/write routers: FSM encoding and
// default geometry constants.
package router_pkg;

  localparam int DefMaxWidth  = 9;
  localparam int DefDepth     = 128;
  localparam int DefDataWidth = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } routerState_t;

endpackage

// File: rtl/write_router_if.sv
// Compute-side vector handshake plus the buffer write port of the write router.
// The master side is the router; the slave side is the compute source / buffer.
interface write_router_if
  import router_pkg::*;
#(
  parameter int MaxWidth  = DefMaxWidth,
  parameter int DataWidth = DefDataWidth,
  parameter int AddrWidth = $clog2(DefDepth)
);

  logic                          inValid;
  logic                          inReady;
  logic [MaxWidth*DataWidth-1:0] dataIn;
  logic                          writeEn;
  logic [AddrWidth-1:0]          writeAddr;
  logic [DataWidth-1:0]          dataOut;

  modport master (
    input  inValid, dataIn,
    output inReady, writeEn, writeAddr, dataOut
  );

  modport slave (
    output inValid, dataIn,
    input  inReady, writeEn, writeAddr, dataOut
  );

endinterface

// File: rtl/write_router_lane_unpacker.sv
// MaxWidth-lane shift register: loads a packed vector, then shifts one lane
// per cycle towards lane 0, which is always presented on laneZero.
module lane_unpacker
  import router_pkg::*;
#(
  parameter int MaxWidth  = DefMaxWidth,
  parameter int DataWidth = DefDataWidth
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic                          shift,
  input  logic [MaxWidth*DataWidth-1:0] vecIn,
  output logic [DataWidth-1:0]          laneZero
);

  logic [MaxWidth*DataWidth-1:0] shiftReg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shiftReg <= '0;
    end else if (load) begin
      shiftReg <= vecIn;
    end else if (shift) begin
      shiftReg <= shiftReg >> DataWidth;
    end
  end

  assign laneZero = shiftReg[DataWidth-1:0];

endmodule

// File: rtl/write_router.sv
// Write router: unpacks packed result vectors and writes them lane by lane to
// consecutive (wrapping) buffer addresses from startAddr through finalAddr.
module write_router
  import router_pkg::*;
#(
  parameter int MaxWidth   = DefMaxWidth,
  parameter int Depth      = DefDepth,
  parameter int DataWidth  = DefDataWidth,
  parameter int AddrWidth  = $clog2(Depth),
  parameter int CountWidth = $clog2(MaxWidth + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  routeEn,
  input  logic [AddrWidth-1:0]  startAddr,
  input  logic [AddrWidth-1:0]  finalAddr,
  input  logic [CountWidth-1:0] laneCount,
  output logic                  finished,
  output logic                  busy,
  write_router_if.master        bus
);

  routerState_t state, nextState;

  logic [AddrWidth-1:0]  ptr;
  logic [AddrWidth-1:0]  finalReg;
  logic [AddrWidth-1:0]  nextPtr;
  logic [CountWidth-1:0] lane;
  logic [CountWidth-1:0] lastLane;
  logic [CountWidth-1:0] effLast;
  logic [DataWidth-1:0]  laneZero;
  logic                  atFinal;
  logic                  startJob;
  logic                  loadVec;
  logic                  shiftVec;

  // Out-of-range lane counts (zero or above MaxWidth) mean a full vector.
  assign effLast = (laneCount == '0 || laneCount > CountWidth'(MaxWidth))
                   ? CountWidth'(MaxWidth - 1)
                   : laneCount - CountWidth'(1);

  assign atFinal = (ptr == finalReg);
  assign nextPtr = (ptr == AddrWidth'(Depth - 1)) ? '0 : ptr + AddrWidth'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    startJob  = 1'b0;
    loadVec   = 1'b0;
    shiftVec  = 1'b0;
    unique case (state)
      IDLE: begin
        if (routeEn) begin
          startJob  = 1'b1;
          nextState = LOAD;
        end
      end
      LOAD: begin
        if (!routeEn) begin
          nextState = IDLE;
        end else if (bus.inValid) begin
          loadVec   = 1'b1;
          nextState = DRAIN;
        end
      end
      DRAIN: begin
        // Abort wins over everything; reaching finalAddr discards leftover lanes.
        if (!routeEn) begin
          nextState = IDLE;
        end else if (atFinal) begin
          nextState = DONE;
        end else begin
          shiftVec = 1'b1;
          if (lane == lastLane) begin
            nextState = LOAD;
          end
        end
      end
      DONE: begin
        if (!routeEn) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= '0;
      finalReg <= '0;
      lastLane <= '0;
      lane     <= '0;
    end else begin
      if (startJob) begin
        ptr      <= startAddr;
        finalReg <= finalAddr;
        lastLane <= effLast;
      end
      if (loadVec) begin
        lane <= '0;
      end
      if (shiftVec) begin
        ptr  <= nextPtr;
        lane <= lane + CountWidth'(1);
      end
    end
  end

  lane_unpacker #(
    .MaxWidth (MaxWidth),
    .DataWidth(DataWidth)
  ) unpacker (
    .clk     (clk),
    .rst     (rst),
    .load    (loadVec),
    .shift   (shiftVec),
    .vecIn   (bus.dataIn),
    .laneZero(laneZero)
  );

  assign bus.inReady   = (state == LOAD);
  assign bus.writeEn   = (state == DRAIN);
  assign bus.writeAddr = ptr;
  assign bus.dataOut   = laneZero;
  assign finished      = (state == DONE);
  assign busy          = (state == LOAD) || (state == DRAIN);

endmodule

// File: tb/tb_write_router.sv
// Directed bench for write_router: a scoreboard of expected buffer writes is
// filled as vectors are presented and drained by a write monitor.
module tb_write_router;
  import router_pkg::*;

  localparam int MaxWidth   = DefMaxWidth;
  localparam int Depth      = DefDepth;
  localparam int DataWidth  = DefDataWidth;
  localparam int AddrWidth  = $clog2(Depth);
  localparam int CountWidth = $clog2(MaxWidth + 1);

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] data;
  } wr_t;

  logic                  clk;
  logic                  rst;
  logic                  routeEn;
  logic [AddrWidth-1:0]  startAddr;
  logic [AddrWidth-1:0]  finalAddr;
  logic [CountWidth-1:0] laneCount;
  logic                  finished;
  logic                  busy;

  write_router_if #(
    .MaxWidth (MaxWidth),
    .DataWidth(DataWidth),
    .AddrWidth(AddrWidth)
  ) bus ();

  write_router #(
    .MaxWidth (MaxWidth),
    .Depth    (Depth),
    .DataWidth(DataWidth)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .routeEn  (routeEn),
    .startAddr(startAddr),
    .finalAddr(finalAddr),
    .laneCount(laneCount),
    .finished (finished),
    .busy     (busy),
    .bus      (bus)
  );

  int  checks = 0;
  int  errors = 0;
  int  jobWrites = 0;
  int  expAddr = 0;
  int  expLeft = 0;
  int  effCount = 0;
  wr_t expQ[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Every write seen on the buffer port must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && bus.writeEn) begin
      jobWrites++;
      if (expQ.size() == 0) begin
        checkOutput("scoreboard underflow", 0, 1);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        checkOutput("write addr", 32'(bus.writeAddr), 32'(e.addr));
        checkOutput("write data", 32'(bus.dataOut), 32'(e.data));
      end
    end
  end

  function automatic logic [MaxWidth*DataWidth-1:0] makeVec(input int base);
    logic [MaxWidth*DataWidth-1:0] v;
    v = '0;
    for (int k = 0; k < MaxWidth; k++) v[k*DataWidth +: DataWidth] = DataWidth'(base + k);
    return v;
  endfunction

  task automatic startJob(input int s, input int f, input int lc);
    startAddr = AddrWidth'(s);
    finalAddr = AddrWidth'(f);
    laneCount = CountWidth'(lc);
    expAddr   = s;
    expLeft   = ((f - s + Depth) % Depth) + 1;
    effCount  = (lc == 0 || lc > MaxWidth) ? MaxWidth : lc;
    jobWrites = 0;
    routeEn   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("start inReady", 32'(bus.inReady), 1);
    checkOutput("start busy", 32'(busy), 1);
  endtask

  task automatic applyStimulus(input logic [MaxWidth*DataWidth-1:0] vec);
    int n;
    bus.dataIn  = vec;
    bus.inValid = 1'b1;
    n = (expLeft < effCount) ? expLeft : effCount;
    for (int k = 0; k < n; k++) begin
      expQ.push_back('{addr: AddrWidth'(expAddr), data: vec[k*DataWidth +: DataWidth]});
      expAddr = (expAddr + 1) % Depth;
    end
    expLeft -= n;
  endtask

  // Waits (bounded) for inReady, lets the next edge take the vector, then
  // returns just after that edge so the next negedge is the first write cycle.
  task automatic waitAccept(input string tag);
    int n = 0;
    while (!bus.inReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(bus.inReady), 1);
    @(posedge clk);
    #1 bus.inValid = 1'b0;
  endtask

  task automatic waitFinished(input string tag);
    int n = 0;
    while (!finished && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(finished), 1);
    checkOutput({tag, " queue empty"}, 32'(expQ.size()), 0);
  endtask

  task automatic endJob(input string tag);
    routeEn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, " finished low"}, 32'(finished), 0);
    checkOutput({tag, " busy low"}, 32'(busy), 0);
  endtask

  initial begin
    rst         = 1'b0;
    routeEn     = 1'b0;
    startAddr   = '0;
    finalAddr   = '0;
    laneCount   = '0;
    bus.inValid = 1'b0;
    bus.dataIn  = '0;
    #2;
    checkOutput("reset inReady", 32'(bus.inReady), 0);
    checkOutput("reset writeEn", 32'(bus.writeEn), 0);
    checkOutput("reset writeAddr", 32'(bus.writeAddr), 0);
    checkOutput("reset dataOut", 32'(bus.dataOut), 0);
    checkOutput("reset finished", 32'(finished), 0);
    checkOutput("reset busy", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Single full vector, nine back-to-back writes then finished.
    startJob(10, 18, 9);
    applyStimulus(makeVec(8'h01));
    waitAccept("t1 accept");
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      checkOutput($sformatf("t1 writeEn lane %0d", k), 32'(bus.writeEn), 1);
    end
    @(negedge clk);
    checkOutput("t1 finished", 32'(finished), 1);
    checkOutput("t1 no write in done", 32'(bus.writeEn), 0);
    waitFinished("t1");
    endJob("t1");

    // Two 4-lane vectors with a single LOAD bubble between them.
    startJob(0, 7, 4);
    applyStimulus(makeVec(8'hA0));
    waitAccept("t2 accept A");
    applyStimulus(makeVec(8'hB0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("t2 writeEn A", 32'(bus.writeEn), 1);
    end
    @(negedge clk);
    checkOutput("t2 bubble writeEn", 32'(bus.writeEn), 0);
    checkOutput("t2 bubble inReady", 32'(bus.inReady), 1);
    waitAccept("t2 accept B");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("t2 writeEn B", 32'(bus.writeEn), 1);
    end
    @(negedge clk);
    checkOutput("t2 finished", 32'(finished), 1);
    waitFinished("t2");
    endJob("t2");

    // Address wrap with truncation of the remaining lanes.
    startJob(126, 1, 9);
    applyStimulus(makeVec(8'h30));
    waitAccept("t3 accept");
    waitFinished("t3");
    checkOutput("t3 write count", 32'(jobWrites), 4);
    endJob("t3");

    // Backpressure: LOAD holds quietly until the source presents data.
    startJob(20, 22, 3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("t4 hold inReady", 32'(bus.inReady), 1);
      checkOutput("t4 hold writeEn", 32'(bus.writeEn), 0);
      checkOutput("t4 hold writeAddr", 32'(bus.writeAddr), 20);
    end
    applyStimulus(makeVec(8'h70));
    waitAccept("t4 accept");
    @(negedge clk);
    checkOutput("t4 resume writeEn", 32'(bus.writeEn), 1);
    waitFinished("t4");
    endJob("t4");

    // Abort after three writes of a nine-write job.
    startJob(60, 68, 9);
    expLeft = 3;
    applyStimulus(makeVec(8'hC0));
    waitAccept("t5 accept");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("t5 writeEn", 32'(bus.writeEn), 1);
    end
    routeEn = 1'b0;
    @(negedge clk);
    checkOutput("t5 abort writeEn", 32'(bus.writeEn), 0);
    checkOutput("t5 abort finished", 32'(finished), 0);
    checkOutput("t5 abort busy", 32'(busy), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("t5 idle writeEn", 32'(bus.writeEn), 0);
    end
    checkOutput("t5 queue empty", 32'(expQ.size()), 0);
    checkOutput("t5 write count", 32'(jobWrites), 3);

    // Asynchronous reset in the middle of DRAIN.
    startJob(0, 8, 9);
    expLeft = 2;
    applyStimulus(makeVec(8'hD0));
    waitAccept("t6 accept");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput("t6 writeEn", 32'(bus.writeEn), 1);
    end
    #1 rst = 1'b0;
    #1;
    checkOutput("t6 rst writeEn", 32'(bus.writeEn), 0);
    checkOutput("t6 rst writeAddr", 32'(bus.writeAddr), 0);
    checkOutput("t6 rst dataOut", 32'(bus.dataOut), 0);
    checkOutput("t6 rst inReady", 32'(bus.inReady), 0);
    checkOutput("t6 rst finished", 32'(finished), 0);
    checkOutput("t6 rst busy", 32'(busy), 0);
    routeEn = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("t6 post-reset busy", 32'(busy), 0);
    checkOutput("t6 queue empty", 32'(expQ.size()), 0);

    // laneCount=0 means full width; single-address job writes lane 0 only.
    startJob(50, 50, 0);
    applyStimulus(makeVec(8'h5A));
    waitAccept("t7 accept");
    @(negedge clk);
    checkOutput("t7 writeEn", 32'(bus.writeEn), 1);
    @(negedge clk);
    checkOutput("t7 finished", 32'(finished), 1);
    checkOutput("t7 write count", 32'(jobWrites), 1);
    waitFinished("t7");
    endJob("t7");

    // laneCount=0 over ten addresses: nine lanes, then one from a second vector.
    startJob(90, 99, 0);
    applyStimulus(makeVec(8'h10));
    waitAccept("t8 accept 1");
    applyStimulus(makeVec(8'h20));
    waitAccept("t8 accept 2");
    waitFinished("t8");
    checkOutput("t8 write count", 32'(jobWrites), 10);
    endJob("t8");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/write_router.md
# write_router

Write-back counterpart of the buffer read router. It accepts packed result vectors of up to MaxWidth elements from the compute side through a valid/ready handshake, unpacks each vector lane by lane, and issues one buffer write per cycle at consecutive addresses from startAddr to finalAddr. It drives the buffer's writeEn/writeAddr/dataIn port directly and raises finished once finalAddr has been written.

## Interface
- MaxWidth, 9, lanes per packed input vector
- Depth, 128, buffer depth in words
- DataWidth, 8, bits per element
- AddrWidth, $clog2(Depth), buffer address width
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- routeEn  in  1  level enable; rising into IDLE starts a job, deassertion aborts
- startAddr  in  AddrWidth  first buffer address written; sampled on job start
- finalAddr  in  AddrWidth  last buffer address written, inclusive; sampled on job start
- laneCount  in  $clog2(MaxWidth+1)  valid lanes per vector; sampled on job start
- inValid  in  1  packed vector on dataIn is valid
- inReady  out  1  block can accept a vector
- dataIn  in  MaxWidth*DataWidth  packed vector; lane 0 = bits [DataWidth-1:0]
- writeEn  out  1  buffer write strobe
- writeAddr  out  AddrWidth  buffer write address
- dataOut  out  DataWidth  buffer write data
- finished  out  1  job complete
- busy  out  1  job in progress (state LOAD or DRAIN)

## Operation
- FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE: if routeEn=1, latch startAddr into ptr, latch finalAddr, latch effective count, and go to LOAD.
- Effective count: laneCount=0 or laneCount>MaxWidth is treated as MaxWidth.
- LOAD: inReady=1. On inValid&inReady, capture dataIn into the lane shift register, set lane=0, and go to DRAIN.
- DRAIN: writeEn=1, writeAddr=ptr, dataOut=lane 0 of the shift register. Each cycle:
  - If ptr==finalAddr, go to DONE; remaining lanes are discarded.
  - Otherwise ptr advances by 1 and the register shifts by DataWidth.
  - If lane==count-1, go to LOAD; otherwise lane advances by 1.
- Address wrap: ptr increments modulo Depth (Depth-1 -> 0). finalAddr<startAddr is legal and wraps. startAddr==finalAddr gives exactly one write.
- DONE: finished=1, with no writes and inReady=0. Hold until routeEn=0, then go to IDLE.
- routeEn=0 in LOAD or DRAIN aborts the job: go to IDLE on the next edge, with no further writes and finished=0.
- inValid while not in LOAD is ignored; the source must hold its data until it sees inReady.

## Timing
- Reset values (rst=0): state=IDLE, inReady=0, writeEn=0, writeAddr=0, dataOut=0, finished=0, busy=0, ptr=0, lane=0, shift register=0.
- All outputs are decoded from registered state only; there are no combinational paths from inputs to outputs.
- Job start: routeEn seen high at edge E gives inReady=1 in cycle E+1.
- Vector accepted at edge N:
  - first write is in cycle N+1;
  - lane k is written in cycle N+1+k.
- Throughput: count writes followed by one LOAD cycle (minimum one bubble) per vector.
- finished rises in the cycle after the write to finalAddr.
- Total write count for a job is (finalAddr-startAddr) mod Depth + 1.

## Structure
- A shared package (router_pkg) holds the FSM state encoding and the default MaxWidth/Depth/DataWidth constants, used by both the read router and write_router.
- Natural sub-module: lane_unpacker, a MaxWidth-lane shift register with load/shift controls and a lane-0 output.
- The FSM, ptr counter and lane counter live in write_router.

## Test plan
- Single vector: start=10, final=18, laneCount=9, dataIn lanes 0x01..0x09 -> writes 0x01..0x09 to addresses 10..18 in 9 consecutive cycles; finished 1 cycle after the last write.
- Multi-vector with bubble: start=0, final=7, laneCount=4, two vectors {A0..A3},{B0..B3} -> addresses 0..3 get A, then a 1-cycle gap with inReady=1, then addresses 4..7 get B; finished.
- Wrap and truncation: start=126, final=1, laneCount=9 -> writes to 126,127,0,1 only (lanes 0..3); lanes 4..8 discarded; finished.
- Backpressure: hold inValid=0 for 5 cycles in LOAD -> inReady stays 1, writeEn stays 0, no address change; writes resume 1 cycle after inValid.
- Abort and reset: drop routeEn after 3 writes of a 9-write job -> IDLE next edge, no further writes, finished=0. Assert rst mid-DRAIN -> all outputs 0 immediately (asynchronously).
- laneCount=0 treated as 9; start=final=50 -> exactly one write of lane 0 to address 50.
